// File: rtl/exe_alu_stage.sv
// Execute stage: operand-2 shifter, 33-bit ALU with NZCV status, branch target adder
// and the EX/MEM pipeline register. Every register is held while freeze is high.
module exe_alu_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic [31:0] pc_in,
  input  logic        wb_en,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic        b,
  input  logic        s,
  input  logic        imm,
  input  logic [3:0]  exe_cmd,
  input  logic [31:0] val_rn,
  input  logic [31:0] val_rm,
  input  logic [11:0] shift_operand,
  input  logic [23:0] signed_imm_24,
  input  logic [3:0]  dest,
  output logic        branch_taken,
  output logic [31:0] branch_addr,
  output logic [3:0]  status,
  output logic        wb_en_out,
  output logic        mem_r_en_out,
  output logic        mem_w_en_out,
  output logic [31:0] alu_result,
  output logic [31:0] val_rm_out,
  output logic [3:0]  dest_out,
  output logic [31:0] pc_out
);

  logic [3:0]  r_status;
  logic [31:0] r_alu_result;
  logic [31:0] r_val_rm;
  logic [3:0]  r_dest;
  logic [31:0] r_pc;
  logic        r_wb_en;
  logic        r_mem_r_en;
  logic        r_mem_w_en;

  logic [31:0] w_imm8;
  logic [5:0]  w_imm_rot;
  logic [4:0]  w_sh_amt;
  logic [31:0] w_val2;
  logic        w_mem_op;
  logic [3:0]  w_cmd;
  logic [32:0] w_wide;
  logic [31:0] w_res;
  logic        w_c;
  logic        w_v;
  logic        w_logic_op;
  logic        w_arith_op;
  logic [3:0]  w_flags;

  assign w_imm8    = {24'd0, shift_operand[7:0]};
  assign w_imm_rot = {1'b0, shift_operand[11:8], 1'b0};
  assign w_sh_amt  = shift_operand[11:7];
  assign w_mem_op  = mem_r_en | mem_w_en;
  assign w_cmd     = w_mem_op ? 4'b0010 : exe_cmd;

  // Right-rotates rely on a shift by 32 yielding zero, so amount 0 passes the value through.
  always_comb begin
    w_val2 = 32'd0;
    if (imm) begin
      w_val2 = (w_imm8 >> w_imm_rot) | (w_imm8 << (6'd32 - w_imm_rot));
    end else if (w_mem_op) begin
      w_val2 = {20'd0, shift_operand};
    end else begin
      case (shift_operand[6:5])
        2'b00:   w_val2 = val_rm << w_sh_amt;
        2'b01:   w_val2 = val_rm >> w_sh_amt;
        2'b10:   w_val2 = $unsigned($signed(val_rm) >>> w_sh_amt);
        default: w_val2 = (val_rm >> w_sh_amt) | (val_rm << (6'd32 - {1'b0, w_sh_amt}));
      endcase
    end
  end

  always_comb begin
    w_wide     = 33'd0;
    w_res      = 32'd0;
    w_c        = r_status[1];
    w_v        = r_status[0];
    w_logic_op = 1'b0;
    w_arith_op = 1'b0;
    case (w_cmd)
      4'b0001: begin w_res = w_val2;           w_logic_op = 1'b1; end
      4'b1001: begin w_res = ~w_val2;          w_logic_op = 1'b1; end
      4'b0110: begin w_res = val_rn & w_val2;  w_logic_op = 1'b1; end
      4'b0111: begin w_res = val_rn | w_val2;  w_logic_op = 1'b1; end
      4'b1000: begin w_res = val_rn ^ w_val2;  w_logic_op = 1'b1; end
      4'b0010, 4'b0011: begin
        w_wide = {1'b0, val_rn} + {1'b0, w_val2} + {32'd0, (w_cmd[0] & r_status[1])};
        w_res  = w_wide[31:0];
        w_c    = w_wide[32];
        w_v    = (val_rn[31] == w_val2[31]) && (w_res[31] != val_rn[31]);
        w_arith_op = 1'b1;
      end
      4'b0100, 4'b0101: begin
        w_wide = {1'b0, val_rn} - {1'b0, w_val2} - {32'd0, (w_cmd[0] & ~r_status[1])};
        w_res  = w_wide[31:0];
        w_c    = ~w_wide[32];
        w_v    = (val_rn[31] != w_val2[31]) && (w_res[31] != val_rn[31]);
        w_arith_op = 1'b1;
      end
      default: w_res = 32'd0;
    endcase
  end

  always_comb begin
    w_flags = r_status;
    if (w_logic_op) w_flags = {w_res[31], (w_res == 32'd0), r_status[1:0]};
    if (w_arith_op) w_flags = {w_res[31], (w_res == 32'd0), w_c, w_v};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_status     <= 4'd0;
      r_alu_result <= 32'd0;
      r_val_rm     <= 32'd0;
      r_dest       <= 4'd0;
      r_pc         <= 32'd0;
      r_wb_en      <= 1'b0;
      r_mem_r_en   <= 1'b0;
      r_mem_w_en   <= 1'b0;
    end else if (!freeze) begin
      if (s) r_status <= w_flags;
      r_alu_result <= w_res;
      r_val_rm     <= val_rm;
      r_dest       <= dest;
      r_pc         <= pc_in;
      r_wb_en      <= wb_en;
      r_mem_r_en   <= mem_r_en;
      r_mem_w_en   <= mem_w_en;
    end
  end

  assign branch_taken = b;
  assign branch_addr  = pc_in + {{6{signed_imm_24[23]}}, signed_imm_24, 2'b00};
  assign status       = r_status;
  assign alu_result   = r_alu_result;
  assign val_rm_out   = r_val_rm;
  assign dest_out     = r_dest;
  assign pc_out       = r_pc;
  assign wb_en_out    = r_wb_en;
  assign mem_r_en_out = r_mem_r_en;
  assign mem_w_en_out = r_mem_w_en;

endmodule

// File: tb/tb_exe_alu_stage.sv
// Directed bench for exe_alu_stage: hand-computed results and NZCV flags per scenario.
module tb_exe_alu_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic [31:0] pc_in = '0;
  logic        wb_en = 1'b0, mem_r_en = 1'b0, mem_w_en = 1'b0, b = 1'b0, s = 1'b0, imm = 1'b0;
  logic [3:0]  exe_cmd = '0;
  logic [31:0] val_rn = '0, val_rm = '0;
  logic [11:0] shift_operand = '0;
  logic [23:0] signed_imm_24 = '0;
  logic [3:0]  dest = '0;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [3:0]  status;
  logic        wb_en_out, mem_r_en_out, mem_w_en_out;
  logic [31:0] alu_result, val_rm_out, pc_out;
  logic [3:0]  dest_out;

  int n_vec = 0;
  int n_err = 0;

  exe_alu_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze), .pc_in(pc_in), .wb_en(wb_en),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .b(b), .s(s), .imm(imm),
    .exe_cmd(exe_cmd), .val_rn(val_rn), .val_rm(val_rm), .shift_operand(shift_operand),
    .signed_imm_24(signed_imm_24), .dest(dest), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .status(status), .wb_en_out(wb_en_out),
    .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out), .alu_result(alu_result),
    .val_rm_out(val_rm_out), .dest_out(dest_out), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                        input logic [11:0] so, input logic im, input logic sv);
    exe_cmd = cmd; val_rn = rn; val_rm = rm; shift_operand = so; imm = im; s = sv;
    mem_r_en = 1'b0; mem_w_en = 1'b0; b = 1'b0; wb_en = 1'b1;
  endtask

  task automatic test_reset();
    pc_in = 32'h1234; dest = 4'hA; val_rm = 32'h5555_AAAA; wb_en = 1'b1;
    #3;
    n_vec++;
    if ({status, alu_result, val_rm_out, dest_out, pc_out, wb_en_out, mem_r_en_out, mem_w_en_out} !== '0) begin
      n_err++; $display("FAIL reset_async res=%h rm=%h pc=%h st=%b", alu_result, val_rm_out, pc_out, status);
    end
    step();
    n_vec++;
    if ({alu_result, val_rm_out, pc_out, dest_out, wb_en_out} !== '0) begin
      n_err++; $display("FAIL reset_held res=%h rm=%h pc=%h want 0", alu_result, val_rm_out, pc_out);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_add_overflow();
    set_op(4'b0010, 32'h7FFF_FFFF, 32'hDEAD_BEEF, 12'h001, 1'b1, 1'b1);
    pc_in = 32'h44; dest = 4'h3;
    step();
    n_vec++;
    if (alu_result !== 32'h8000_0000) begin n_err++; $display("FAIL add_res got %h want 80000000", alu_result); end
    n_vec++;
    if (status !== 4'b1001) begin n_err++; $display("FAIL add_flags got %b want 1001", status); end
    n_vec++;
    if ({val_rm_out, pc_out, dest_out, wb_en_out} !== {32'hDEAD_BEEF, 32'h44, 4'h3, 1'b1}) begin
      n_err++; $display("FAIL add_pipe rm=%h pc=%h dest=%h wb=%b", val_rm_out, pc_out, dest_out, wb_en_out);
    end
  endtask

  task automatic test_sub_adc_sbc();
    set_op(4'b0100, 32'd5, 32'd0, 12'h005, 1'b1, 1'b1);
    step();
    n_vec++;
    if ({alu_result, status} !== {32'd0, 4'b0110}) begin
      n_err++; $display("FAIL sub_eq got %h/%b want 00000000/0110", alu_result, status);
    end
    set_op(4'b0011, 32'd1, 32'd0, 12'h001, 1'b1, 1'b1);
    step();
    n_vec++;
    if ({alu_result, status} !== {32'd3, 4'b0000}) begin
      n_err++; $display("FAIL adc_carry got %h/%b want 00000003/0000", alu_result, status);
    end
    set_op(4'b0101, 32'd10, 32'd0, 12'h003, 1'b1, 1'b1);
    step();
    n_vec++;
    if ({alu_result, status} !== {32'd6, 4'b0010}) begin
      n_err++; $display("FAIL sbc_borrow got %h/%b want 00000006/0010", alu_result, status);
    end
  endtask

  task automatic test_imm_rotate();
    set_op(4'b0001, 32'd0, 32'd0, 12'h4FF, 1'b1, 1'b1);
    step();
    n_vec++;
    if ({alu_result, status} !== {32'hFF00_0000, 4'b1010}) begin
      n_err++; $display("FAIL mov_rot got %h/%b want ff000000/1010", alu_result, status);
    end
    set_op(4'b1001, 32'd0, 32'd0, 12'h000, 1'b1, 1'b0);
    step();
    n_vec++;
    if ({alu_result, status} !== {32'hFFFF_FFFF, 4'b1010}) begin
      n_err++; $display("FAIL mvn_nos got %h/%b want ffffffff/1010", alu_result, status);
    end
  endtask

  task automatic test_logic_ops();
    logic [3:0]  cmds [3] = '{4'b0110, 4'b0111, 4'b1000};
    logic [31:0] exp  [3] = '{32'h00F0_00F0, 32'hFFF0_FFF0, 32'hFF00_FF00};
    for (int i = 0; i < 3; i++) begin
      set_op(cmds[i], 32'hF0F0_F0F0, 32'h0FF0_0FF0, 12'h000, 1'b0, 1'b0);
      step();
      n_vec++;
      if (alu_result !== exp[i]) begin
        n_err++; $display("FAIL logic_%0d got %h want %h", i, alu_result, exp[i]);
      end
    end
  endtask

  task automatic test_shifts();
    logic [31:0] rms [6] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0001,
                             32'h8000_0000, 32'h0000_000F, 32'h8000_0001};
    logic [11:0] sos [6] = '{12'h240, 12'h060, 12'h200, 12'h220, 12'h260, 12'h0E0};
    logic [31:0] exp [6] = '{32'hF800_0000, 32'h8000_0000, 32'h0000_0010,
                             32'h0800_0000, 32'hF000_0000, 32'hC000_0000};
    for (int i = 0; i < 6; i++) begin
      set_op(4'b0001, 32'd0, rms[i], sos[i], 1'b0, 1'b0);
      step();
      n_vec++;
      if (alu_result !== exp[i]) begin
        n_err++; $display("FAIL shift_%0d so=%h got %h want %h", i, sos[i], alu_result, exp[i]);
      end
    end
  endtask

  task automatic test_invalid_cmd();
    set_op(4'b0000, 32'h1234_5678, 32'd0, 12'h0FF, 1'b1, 1'b1);
    step();
    n_vec++;
    if ({alu_result, status} !== {32'd0, 4'b1010}) begin
      n_err++; $display("FAIL bad_cmd0 got %h/%b want 00000000/1010", alu_result, status);
    end
    set_op(4'b1111, 32'h1234_5678, 32'd0, 12'h0FF, 1'b1, 1'b1);
    step();
    n_vec++;
    if ({alu_result, status} !== {32'd0, 4'b1010}) begin
      n_err++; $display("FAIL bad_cmdf got %h/%b want 00000000/1010", alu_result, status);
    end
  endtask

  task automatic test_mem_force();
    set_op(4'b0110, 32'h0000_1000, 32'hCAFE_F00D, 12'h004, 1'b0, 1'b0);
    mem_w_en = 1'b1; wb_en = 1'b0;
    step();
    n_vec++;
    if ({alu_result, val_rm_out, mem_w_en_out, mem_r_en_out, wb_en_out} !== {32'h1004, 32'hCAFE_F00D, 3'b100}) begin
      n_err++; $display("FAIL mem_str got %h rm=%h w=%b r=%b", alu_result, val_rm_out, mem_w_en_out, mem_r_en_out);
    end
    set_op(4'b1000, 32'h0000_2000, 32'd0, 12'hFFC, 1'b0, 1'b0);
    mem_r_en = 1'b1;
    step();
    n_vec++;
    if ({alu_result, mem_r_en_out, mem_w_en_out} !== {32'h2FFC, 2'b10}) begin
      n_err++; $display("FAIL mem_ldr got %h r=%b w=%b", alu_result, mem_r_en_out, mem_w_en_out);
    end
  endtask

  task automatic test_branch();
    set_op(4'b0001, 32'd0, 32'd0, 12'h000, 1'b1, 1'b0);
    b = 1'b1; wb_en = 1'b0; pc_in = 32'h100; signed_imm_24 = 24'hFFFFFE; dest = 4'h0;
    #1;
    n_vec++;
    if ({branch_taken, branch_addr} !== {1'b1, 32'h0F8}) begin
      n_err++; $display("FAIL br_back got %b/%h want 1/000000f8", branch_taken, branch_addr);
    end
    step();
    n_vec++;
    if ({wb_en_out, pc_out} !== {1'b0, 32'h100}) begin
      n_err++; $display("FAIL br_pipe got wb=%b pc=%h want 0/00000100", wb_en_out, pc_out);
    end
    b = 1'b0; pc_in = 32'hFFFF_FFFC; signed_imm_24 = 24'h000002;
    #1;
    n_vec++;
    if ({branch_taken, branch_addr} !== {1'b0, 32'h4}) begin
      n_err++; $display("FAIL br_wrap got %b/%h want 0/00000004", branch_taken, branch_addr);
    end
  endtask

  task automatic test_carry_out();
    set_op(4'b0010, 32'hFFFF_FFFF, 32'd0, 12'h001, 1'b1, 1'b1);
    step();
    n_vec++;
    if ({alu_result, status} !== {32'd0, 4'b0110}) begin
      n_err++; $display("FAIL add_cout got %h/%b want 00000000/0110", alu_result, status);
    end
  endtask

  task automatic test_freeze_reset();
    set_op(4'b0001, 32'd0, 32'h1111_1111, 12'h0AB, 1'b1, 1'b1);
    pc_in = 32'h200; dest = 4'h7;
    step();
    n_vec++;
    if ({alu_result, status, dest_out} !== {32'hAB, 4'b0010, 4'h7}) begin
      n_err++; $display("FAIL pre_frz got %h/%b/%h want 000000ab/0010/7", alu_result, status, dest_out);
    end
    freeze = 1'b1;
    set_op(4'b0100, 32'd0, 32'h2222_2222, 12'h0CD, 1'b1, 1'b1);
    pc_in = 32'h300; dest = 4'h9;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if ({alu_result, status, dest_out, pc_out, val_rm_out} !== {32'hAB, 4'b0010, 4'h7, 32'h200, 32'h1111_1111}) begin
        n_err++; $display("FAIL frz_hold_%0d got %h/%b/%h pc=%h", i, alu_result, status, dest_out, pc_out);
      end
    end
    #2;
    rst = 1'b0;
    #1;
    n_vec++;
    if ({status, alu_result, val_rm_out, dest_out, pc_out, wb_en_out, mem_r_en_out, mem_w_en_out} !== '0) begin
      n_err++; $display("FAIL mid_rst got %h/%b pc=%h want all 0", alu_result, status, pc_out);
    end
    @(negedge clk);
    rst = 1'b1; freeze = 1'b0;
    set_op(4'b0001, 32'd0, 32'h3333_3333, 12'h0CD, 1'b1, 1'b1);
    step();
    n_vec++;
    if ({alu_result, status, dest_out, pc_out} !== {32'hCD, 4'b0000, 4'h9, 32'h300}) begin
      n_err++; $display("FAIL post_rst got %h/%b/%h pc=%h want 000000cd/0000/9/300", alu_result, status, dest_out, pc_out);
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_adc_sbc();
    test_imm_rotate();
    test_logic_ops();
    test_shifts();
    test_invalid_cmd();
    test_mem_force();
    test_branch();
    test_carry_out();
    test_freeze_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/exe_alu_stage.md
EXE_ALU_STAGE -- requirements
Module: exe_alu_stage

Interface
REQ-001 SHALL have these ports, clock and reset first:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- freeze  in  1  hold all registers.
- pc_in  in  32  instruction PC+4 from ID/EX.
- wb_en, mem_r_en, mem_w_en, b, s, imm  in  1 each  decoded controls.
- exe_cmd  in  4  ALU op.
- val_rn, val_rm  in  32  register operands.
- shift_operand  in  12  operand-2 field.
- signed_imm_24  in  24  branch offset.
- dest  in  4  destination register.
- branch_taken  out  1  combinational branch request.
- branch_addr  out  32  combinational branch target.
- status  out  4  registered NZCV, bits [3:0] = {N,Z,C,V}.
- wb_en_out, mem_r_en_out, mem_w_en_out  out  1 each  registered controls.
- alu_result  out  32  registered result.
- val_rm_out  out  32  registered store data.
- dest_out  out  4  registered destination.
- pc_out  out  32  registered PC.
REQ-002 SHALL use one clock domain; rst is the only asynchronous input.

Function
REQ-003 SHALL form val2 combinationally:
- imm=1: {24'b0, shift_operand[7:0]} rotated right by 2*shift_operand[11:8].
- else if mem_r_en|mem_w_en: {20'b0, shift_operand}.
- else: val_rm shifted by shift_operand[11:7], type shift_operand[6:5] = 00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-004 SHALL compute res by exe_cmd:
- 0001 = val2.
- 1001 = ~val2.
- 0010 = rn+val2.
- 0011 = rn+val2+C.
- 0100 = rn-val2.
- 0101 = rn-val2-!C.
- 0110 = rn&val2.
- 0111 = rn|val2.
- 1000 = rn^val2.
- Any other code: res = 0, flags unchanged.
REQ-005 SHALL force exe_cmd to add (0010) when mem_r_en or mem_w_en is 1.
REQ-006 Arithmetic SHALL be 33-bit: C = bit 32 for adds and NOT borrow for subtracts; V = signed overflow.
REQ-007 Logical/move ops SHALL update N and Z only; C and V are held.
REQ-008 SHALL set N = res[31] and Z = (res == 0).
REQ-009 Status register SHALL load the new flags on a rising edge only when s=1 and freeze=0.
REQ-010 ADC/SBC SHALL use the status C value registered before the current edge.
REQ-011 branch_taken SHALL equal b.
REQ-012 branch_addr SHALL equal pc_in + (sign_extend(signed_imm_24) << 2), modulo 2^32.
REQ-013 EX/MEM register SHALL capture res, val_rm, dest, pc_in, wb_en, mem_r_en and mem_w_en on every rising edge with freeze=0.
REQ-014 Registered outputs SHALL have 1-cycle latency.
REQ-015 freeze=1 SHALL hold the EX/MEM register and the status register unchanged.
REQ-016 Branch/compare instructions (wb_en=0) SHALL still propagate through the EX/MEM register unchanged.
REQ-017 Shift amount 0 SHALL pass val_rm unmodified for all four shift types.
REQ-018 ROR amounts SHALL be taken modulo 32.

Reset
REQ-019 rst=0 SHALL immediately clear status, alu_result, val_rm_out, dest_out, pc_out, wb_en_out, mem_r_en_out and mem_w_en_out to 0, independent of clk.
REQ-020 Reset asserted mid-operation SHALL discard the in-flight result.
REQ-021 The first capture after rst rises SHALL occur on the next rising edge with freeze=0.

Verification
REQ-022 The bench SHALL cover:
- ADD: rn=0x7FFFFFFF, imm=1, shift_operand=0x001, s=1 -> next edge alu_result=0x80000000, status=4'b1001.
- SUB: rn=5, val2=5, s=1 -> alu_result=0, status=4'b0110; then ADC rn=1, val2=1 -> alu_result=3.
- Immediate rotate: imm=1, shift_operand=0x4FF -> val2=0xFF000000; MOV yields alu_result=0xFF000000, N=1.
- Shifts: ASR val_rm=0x80000000 by 4 (shift_operand=0x240) -> 0xF8000000; ROR by 0 -> 0x80000000 unchanged.
- Branch: pc_in=0x100, signed_imm_24=0xFFFFFE, b=1 -> branch_taken=1, branch_addr=0x0F8.
- Freeze then reset: freeze=1 for 3 edges -> outputs and status held; rst=0 between edges -> all registered outputs 0 before the next edge.
